// File: rtl/systolic_skew_feeder.sv
// systolic_skew_feeder
//   Accepts column vectors (one beat per cycle) and skews them so lane i sees
//   each beat i+1 cycles after it is accepted, as needed to feed the row delay
//   lines of a systolic array. A burst ends on in_last or after K beats; the
//   feeder then drains for N cycles with in_ready low and pulses done when the
//   final beat leaves the last lane.
//
//   Ports:
//     clk, rst              clock, synchronous active-high reset
//     in_valid/in_ready     input handshake (in_ready never looks at in_valid)
//     in_data [N*D_W]       column vector, lane i at [i*D_W +: D_W]
//     in_last               final beat of burst (sampled on accept)
//     out_data [N*D_W]      skewed lane data
//     out_valid/out_last[N] per-lane valid and final-beat marker
//     done                  one-cycle pulse in the last drain cycle
//
//   Build option: SKEW_ZERO_GATE_EN -- when defined, a lane's data reads 0
//   whenever its valid is 0; otherwise lane data holds across bubbles.
module systolic_skew_feeder #(
  parameter int D_W = 8,
  parameter int N   = 4,
  parameter int K   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N*D_W-1:0] in_data,
  input  logic             in_last,
  output logic [N*D_W-1:0] out_data,
  output logic [N-1:0]     out_valid,
  output logic [N-1:0]     out_last,
  output logic             done
);
  localparam int CW  = (K > 1) ? $clog2(K) : 1;
  localparam int DCW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [DCW-1:0] dcnt;
  logic           acc, term;

  // Ready is held low during reset so nothing is accepted then, and rises in
  // the very first cycle after reset releases.
  assign in_ready = ~rst && (state != DRAIN);
  assign acc      = in_valid && in_ready;
  // in_last on the K-th beat is the same single termination.
  assign term     = in_last || (cnt == CW'(K - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      dcnt  <= '0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE, STREAM: begin
          if (acc) begin
            if (term) begin
              state <= DRAIN;
              cnt   <= '0;
              dcnt  <= '0;
              done  <= (N == 1);
            end else begin
              state <= STREAM;
              cnt   <= cnt + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (dcnt == DCW'(N - 1)) begin
            state <= IDLE;
            done  <= 1'b0;
          end else begin
            dcnt <= dcnt + 1'b1;
            // done is registered, so raise it one cycle ahead of the last drain cycle
            done <= (int'(dcnt) + 2 == N);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Skew pipeline. Stage s carries only lanes s..N-1; its lowest lane is the
  // output for lane s and the rest is handed to stage s+1.
  for (genvar s = 0; s < N; s++) begin : g_stage
    localparam int SW = (N - s) * D_W;
    logic          v_in, l_in, v, l;
    logic [SW-1:0] d_in, d;

    if (s == 0) begin : g_head
      assign v_in = acc;
      assign l_in = acc & in_last;
      assign d_in = in_data;
    end else begin : g_tail
      assign v_in = g_stage[s-1].v;
      assign l_in = g_stage[s-1].l;
      assign d_in = g_stage[s-1].d[SW+D_W-1:D_W];
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        v <= 1'b0;
        l <= 1'b0;
        d <= '0;
      end else begin
        v <= v_in;
        l <= l_in;
`ifdef SKEW_ZERO_GATE_EN
        d <= v_in ? d_in : '0;
`else
        if (v_in) d <= d_in;
`endif
      end
    end

    assign out_valid[s]            = v;
    assign out_last[s]             = l;
    assign out_data[s*D_W +: D_W]  = d[D_W-1:0];
  end
endmodule

// File: tb/tb_systolic_skew_feeder.sv
module tb_systolic_skew_feeder;
  localparam int NC = 2500;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // instance a: N=4, K=8 ; instance b: N=1, K=1
  logic        a_v, a_rdy, a_l, a_done;
  logic [31:0] a_d, a_od;
  logic [3:0]  a_ov, a_ol;
  logic        b_v, b_rdy, b_l, b_done;
  logic [7:0]  b_d, b_od;
  logic [0:0]  b_ov, b_ol;

  systolic_skew_feeder #(.D_W(8), .N(4), .K(8)) u_a (
    .clk(clk), .rst(rst), .in_valid(a_v), .in_ready(a_rdy), .in_data(a_d),
    .in_last(a_l), .out_data(a_od), .out_valid(a_ov), .out_last(a_ol), .done(a_done));

  systolic_skew_feeder #(.D_W(8), .N(1), .K(1)) u_b (
    .clk(clk), .rst(rst), .in_valid(b_v), .in_ready(b_rdy), .in_data(b_d),
    .in_last(b_l), .out_data(b_od), .out_valid(b_ov), .out_last(b_ol), .done(b_done));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: accept history indexed by edge number. Lane i after
  // edge e shows whatever was accepted at edge e-i.
  int          nn[2] = '{4, 1};
  int          kk[2] = '{8, 1};
  bit          hv[2][NC];
  bit          hl[2][NC];
  logic [31:0] hd[2][NC];
  int          beats[2], drain[2];
  logic [7:0]  lastd[2][4];

  task automatic model_edge(input int m, input int e);
    bit v, l;
    logic [31:0] d;
    v = (m == 0) ? a_v : b_v;
    l = (m == 0) ? a_l : b_l;
    d = (m == 0) ? a_d : {24'h0, b_d};
    hv[m][e] = 1'b0;
    hl[m][e] = 1'b0;
    hd[m][e] = d;
    if (rst) begin
      beats[m] = 0;
      drain[m] = 0;
      for (int j = 0; j <= nn[m]; j++)
        if (e - j >= 0) hv[m][e-j] = 1'b0;
      for (int i = 0; i < 4; i++) lastd[m][i] = 8'h0;
    end else if (drain[m] > 0) begin
      drain[m]--;
    end else if (v) begin
      hv[m][e] = 1'b1;
      hl[m][e] = l;
      if (l || beats[m] == kk[m] - 1) begin
        drain[m] = nn[m];
        beats[m] = 0;
      end else begin
        beats[m]++;
      end
    end
  endtask

  task automatic model_check(input int m, input int e);
    bit ev, el;
    logic [7:0] ed, xd, gd;
    bit gv, gl;
    for (int i = 0; i < nn[m]; i++) begin
      ev = 1'b0; el = 1'b0; ed = 8'h0;
      if (e - i >= 0) begin
        ev = hv[m][e-i];
        el = ev && hl[m][e-i];
        ed = hd[m][e-i][i*8 +: 8];
      end
      if (ev) lastd[m][i] = ed;
`ifdef SKEW_ZERO_GATE_EN
      xd = ev ? ed : 8'h0;
`else
      xd = lastd[m][i];
`endif
      gv = (m == 0) ? a_ov[i] : b_ov[0];
      gl = (m == 0) ? a_ol[i] : b_ol[0];
      gd = (m == 0) ? a_od[i*8 +: 8] : b_od;
      chk($sformatf("inst%0d e%0d valid[%0d]", m, e, i), 32'(gv), 32'(ev));
      chk($sformatf("inst%0d e%0d last[%0d]", m, e, i), 32'(gl), 32'(el));
      chk($sformatf("inst%0d e%0d data[%0d]", m, e, i), 32'(gd), 32'(xd));
    end
    chk($sformatf("inst%0d e%0d done", m, e),
        32'((m == 0) ? a_done : b_done), 32'(drain[m] == 1));
    chk($sformatf("inst%0d e%0d ready", m, e),
        32'((m == 0) ? a_rdy : b_rdy), 32'(!rst && drain[m] == 0));
  endtask

  typedef struct {bit r; bit v; bit l; logic [31:0] d;} stim_t;
  stim_t script[$];

  task automatic push(input bit r, input bit v, input bit l, input logic [31:0] d, input int n);
    stim_t s;
    s.r = r; s.v = v; s.l = l; s.d = d;
    for (int k = 0; k < n; k++) script.push_back(s);
  endtask

  task automatic next_inputs(input bool_t_dummy);
  endtask

  task automatic drive();
    stim_t s;
    if (script.size() > 0) begin
      s = script.pop_front();
      rst = s.r; a_v = s.v; a_l = s.l; a_d = s.d;
    end else begin
      rst = ($urandom_range(0, 199) == 0);
      a_v = ($urandom_range(0, 99) < 70);
      a_l = ($urandom_range(0, 99) < 15);
      a_d = $urandom;
    end
    b_v = ($urandom_range(0, 99) < 70);
    b_l = ($urandom_range(0, 3) == 0);
    b_d = 8'($urandom);
  endtask

  initial begin
    push(1, 0, 0, 0, 3);                          // reset
    push(0, 0, 0, 0, 2);
    push(0, 1, 1, 32'h04030201, 1);               // single beat
    push(0, 0, 0, 0, 6);
    for (int k = 0; k < 8; k++) push(0, 1, 0, $urandom, 1);  // full burst, K forces end
    push(0, 0, 0, 0, 6);
    push(0, 1, 0, 32'haabbccdd, 1);               // bubble: A, gap, B(last)
    push(0, 0, 0, 32'h11111111, 1);
    push(0, 1, 1, 32'h55667788, 1);
    push(0, 0, 0, 0, 6);
    push(0, 1, 0, 32'h01010101, 2);               // backpressure: valid held through drain
    push(0, 1, 1, 32'h02020202, 1);
    push(0, 1, 0, 32'h03030303, 8);
    push(0, 1, 1, 32'h04040404, 1);
    push(0, 0, 0, 0, 8);
    push(0, 1, 1, 32'h0a0b0c0d, 1);               // reset in the 2nd drain cycle
    push(0, 0, 0, 0, 1);
    push(1, 0, 0, 0, 1);
    push(0, 0, 0, 0, 2);
    push(0, 1, 1, 32'h04030201, 1);               // single beat again
    push(0, 0, 0, 0, 6);

    drive();
    for (int e = 0; e < NC; e++) begin
      @(posedge clk);
      model_edge(0, e);
      model_edge(1, e);
      @(negedge clk);
      model_check(0, e);
      model_check(1, e);
      drive();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
